// File: rtl/cache_pkg.sv
// Shared types and default geometry for the L1 data cache data array.
package cache_pkg;

  localparam int unsigned INDEX_BITS_DEFAULT  = 3;
  localparam int unsigned OFFSET_BITS_DEFAULT = 2;
  localparam int unsigned WAY_BITS_DEFAULT    = 1;
  localparam int unsigned DATA_WIDTH_DEFAULT  = 32;

  localparam int unsigned NUM_SETS       = 2 ** INDEX_BITS_DEFAULT;
  localparam int unsigned WORDS_PER_LINE = 2 ** OFFSET_BITS_DEFAULT;
  localparam int unsigned NUM_WAYS       = 2 ** WAY_BITS_DEFAULT;
  localparam int unsigned NUM_LANES      = DATA_WIDTH_DEFAULT / 8;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEvictRd,
    StEvictOut
  } state_e;

  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/cache_data_bank.sv
// One way of the data array: single read/write port, per-byte write enables.
// Reads are combinational; the top level registers whatever it needs.
module cache_data_bank #(
  parameter int unsigned AddrBits  = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [AddrBits-1:0]    addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   rdata_o
);

  localparam int unsigned Lanes = DataWidth / 8;
  localparam int unsigned Depth = 2 ** AddrBits;

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < Lanes; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cache_data_array.sv
// L1 data cache data store: port A for core loads/stores, port B for line refill
// and eviction bursts sequenced by a small FSM with a word counter.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = 3,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned WAY_BITS    = 1,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    i_core_req,
  input  logic                    i_core_we,
  input  logic [INDEX_BITS-1:0]   i_index,
  input  logic [OFFSET_BITS-1:0]  i_offset,
  input  logic [WAY_BITS-1:0]     i_way,
  input  logic [DATA_WIDTH/8-1:0] i_dm_write,
  input  logic [DATA_WIDTH-1:0]   i_data_from_core,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_data_valid,
  output logic                    o_busy,
  input  logic                    i_fill_start,
  input  logic                    i_evict_start,
  input  logic [INDEX_BITS-1:0]   i_line_index,
  input  logic [WAY_BITS-1:0]     i_line_way,
  input  logic                    i_fill_valid,
  input  logic [DATA_WIDTH-1:0]   i_data_from_mem,
  output logic                    o_fill_done,
  output logic                    o_evict_valid,
  output logic [DATA_WIDTH-1:0]   o_evict_data,
  output logic                    o_evict_last,
  input  logic                    i_evict_ready
);

  localparam int unsigned ArrayWays = 2 ** WAY_BITS;
  localparam int unsigned Lanes     = lane_count(DATA_WIDTH);
  localparam int unsigned AddrBits  = INDEX_BITS + OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LastWord = '1;

  state_e                  state_q, state_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]   line_index_q, line_index_d;
  logic [WAY_BITS-1:0]     line_way_q, line_way_d;

  logic [DATA_WIDTH-1:0]   data_q;
  logic                    data_valid_q;
  logic                    fill_done_q;
  logic [DATA_WIDTH-1:0]   evict_data_q;

  logic                    idle;
  logic                    cnt_last;
  logic                    core_rd;
  logic                    core_wr;
  logic                    fill_wr;

  logic                    bank_wr;
  logic [AddrBits-1:0]     bank_addr;
  logic [WAY_BITS-1:0]     bank_way;
  logic [Lanes-1:0]        bank_be;
  logic [DATA_WIDTH-1:0]   bank_wdata;
  logic [DATA_WIDTH-1:0]   bank_rdata [ArrayWays];
  logic [DATA_WIDTH-1:0]   rd_word;

  assign idle     = (state_q == StIdle);
  assign cnt_last = (cnt_q == LastWord);
  assign core_rd  = idle & i_core_req & ~i_core_we;
  assign core_wr  = idle & i_core_req & i_core_we;
  assign fill_wr  = (state_q == StFill) & i_fill_valid;

  // Port A owns the array in IDLE; once a burst starts port B owns it exclusively.
  always_comb begin
    bank_wr    = core_wr | fill_wr;
    bank_addr  = {line_index_q, cnt_q};
    bank_way   = line_way_q;
    bank_be    = '1;
    bank_wdata = i_data_from_mem;
    if (idle) begin
      bank_addr  = {i_index, i_offset};
      bank_way   = i_way;
      bank_be    = i_dm_write;
      bank_wdata = i_data_from_core;
    end
  end

  for (genvar w = 0; w < ArrayWays; w++) begin : g_way
    cache_data_bank #(
      .AddrBits  (AddrBits),
      .DataWidth (DATA_WIDTH)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_wr && (bank_way == WAY_BITS'(w))),
      .be_i    (bank_be),
      .addr_i  (bank_addr),
      .wdata_i (bank_wdata),
      .rdata_o (bank_rdata[w])
    );
  end

  assign rd_word = bank_rdata[bank_way];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_index_d = line_index_q;
    line_way_d   = line_way_q;
    unique case (state_q)
      StIdle: begin
        // Evict wins if both starts arrive together; the fill is dropped.
        if (i_evict_start || i_fill_start) begin
          line_index_d = i_line_index;
          line_way_d   = i_line_way;
          cnt_d        = '0;
          state_d      = i_evict_start ? StEvictRd : StFill;
        end
      end
      StFill: begin
        if (i_fill_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_last) begin
            state_d = StIdle;
          end
        end
      end
      StEvictRd: begin
        state_d = StEvictOut;
      end
      StEvictOut: begin
        if (i_evict_ready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StEvictRd;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      line_index_q <= '0;
      line_way_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_index_q <= line_index_d;
      line_way_q   <= line_way_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
      fill_done_q  <= 1'b0;
      evict_data_q <= '0;
    end else begin
      data_valid_q <= core_rd;
      fill_done_q  <= fill_wr & cnt_last;
      if (core_rd) begin
        data_q <= rd_word;
      end
      // Captured once per word and held through any ready back-pressure.
      if (state_q == StEvictRd) begin
        evict_data_q <= rd_word;
      end
    end
  end

  assign o_data        = data_q;
  assign o_data_valid  = data_valid_q;
  assign o_fill_done   = fill_done_q;
  assign o_busy        = ~idle;
  assign o_evict_valid = (state_q == StEvictOut);
  assign o_evict_data  = evict_data_q;
  assign o_evict_last  = (state_q == StEvictOut) & cnt_last;

endmodule

// File: tb/tb_cache_data_array.sv
// Scoreboard bench for cache_data_array: drivers push expectations computed from a
// flat array model, and a negedge monitor pops and compares whatever the DUT emits.
module tb_cache_data_array;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_core_req, i_core_we;
  logic [2:0]  i_index;
  logic [1:0]  i_offset;
  logic [0:0]  i_way;
  logic [3:0]  i_dm_write;
  logic [31:0] i_data_from_core;
  logic [31:0] o_data;
  logic        o_data_valid, o_busy;
  logic        i_fill_start, i_evict_start;
  logic [2:0]  i_line_index;
  logic [0:0]  i_line_way;
  logic        i_fill_valid;
  logic [31:0] i_data_from_mem;
  logic        o_fill_done, o_evict_valid, o_evict_last, i_evict_ready;
  logic [31:0] o_evict_data;

  cache_data_array dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_core_req       (i_core_req),
    .i_core_we        (i_core_we),
    .i_index          (i_index),
    .i_offset         (i_offset),
    .i_way            (i_way),
    .i_dm_write       (i_dm_write),
    .i_data_from_core (i_data_from_core),
    .o_data           (o_data),
    .o_data_valid     (o_data_valid),
    .o_busy           (o_busy),
    .i_fill_start     (i_fill_start),
    .i_evict_start    (i_evict_start),
    .i_line_index     (i_line_index),
    .i_line_way       (i_line_way),
    .i_fill_valid     (i_fill_valid),
    .i_data_from_mem  (i_data_from_mem),
    .o_fill_done      (o_fill_done),
    .o_evict_valid    (o_evict_valid),
    .o_evict_data     (o_evict_data),
    .o_evict_last     (o_evict_last),
    .i_evict_ready    (i_evict_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: mem[way][set][word].
  logic [31:0] mem [2][8][4];

  typedef struct { logic [31:0] data; int at; } ld_t;
  typedef struct { logic [31:0] data; logic last; } ev_t;
  ld_t ld_q[$];
  int  fd_q[$];
  ev_t ev_q[$];

  logic [31:0] fill_data [4];
  int          fill_gap  [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  ld_t         ld_e;
  ev_t         ev_e;
  int          fd_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_ev;
  always @(negedge clk) begin
    if (!nrst) begin
      prev_stall = 1'b0;
    end else begin
      if (o_data_valid) begin
        if (ld_q.size() == 0) chk("stray_load_valid", 64'(o_data_valid), 64'd0);
        else begin
          ld_e = ld_q.pop_front();
          chk("load_data", 64'(o_data), 64'(ld_e.data));
          chk("load_latency", 64'(cyc), 64'(ld_e.at));
        end
      end
      if (o_fill_done) begin
        if (fd_q.size() == 0) chk("stray_fill_done", 64'(o_fill_done), 64'd0);
        else begin
          fd_e = fd_q.pop_front();
          chk("fill_done_cycle", 64'(cyc), 64'(fd_e));
        end
      end
      if (prev_stall) begin
        chk("evict_hold_valid", 64'(o_evict_valid), 64'd1);
        chk("evict_hold_data", 64'(o_evict_data), 64'(prev_ev));
      end
      if (!o_evict_valid && o_evict_last) chk("evict_last_no_valid", 64'(o_evict_last), 64'd0);
      if (o_evict_valid) begin
        if (ev_q.size() == 0) chk("stray_evict_valid", 64'(o_evict_valid), 64'd0);
        else begin
          chk("evict_last", 64'(o_evict_last), 64'(ev_q[0].last));
          if (i_evict_ready) begin
            ev_e = ev_q.pop_front();
            chk("evict_data", 64'(o_evict_data), 64'(ev_e.data));
          end
        end
      end
      prev_stall = o_evict_valid && !i_evict_ready;
      prev_ev    = o_evict_data;
    end
  end

  task automatic core_op(input bit we, input logic [0:0] way, input logic [2:0] idx,
                         input logic [1:0] off, input logic [3:0] be, input logic [31:0] d);
    i_core_req = 1'b1; i_core_we = we; i_way = way; i_index = idx; i_offset = off;
    i_dm_write = be; i_data_from_core = d;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem[way][idx][off][8*b +: 8] = d[8*b +: 8];
    end else begin
      ld_q.push_back('{mem[way][idx][off], cyc + 1});
    end
    tick();
    i_core_req = 1'b0; i_core_we = 1'b0;
  endtask

  // Refill a line from fill_data/fill_gap. co_load: core load in the start cycle.
  // poke: a store and a load to way1/set0/word0 during word 1's gap must be ignored.
  task automatic fill(input logic [0:0] way, input logic [2:0] idx, input bit co_load,
                      input bit poke);
    logic [0:0] lw; logic [2:0] li; logic [1:0] lo;
    i_fill_start = 1'b1; i_line_index = idx; i_line_way = way;
    if (co_load) begin
      lw = 1'($urandom); li = 3'($urandom); lo = 2'($urandom);
      i_core_req = 1'b1; i_core_we = 1'b0; i_way = lw; i_index = li; i_offset = lo;
      ld_q.push_back('{mem[lw][li][lo], cyc + 1});
    end
    tick();
    i_fill_start = 1'b0; i_core_req = 1'b0;
    chk("busy_fill_start", 64'(o_busy), 64'd1);
    for (int w = 0; w < 4; w++) begin
      for (int g = 0; g < fill_gap[w]; g++) begin
        if (poke && w == 1 && g < 2) begin
          i_core_req = 1'b1; i_core_we = (g == 0); i_way = 1'b1; i_index = 3'd0;
          i_offset = 2'd0; i_dm_write = 4'hf; i_data_from_core = 32'hBADC0DE0;
        end
        tick();
        i_core_req = 1'b0; i_core_we = 1'b0;
        chk("busy_fill_gap", 64'(o_busy), 64'd1);
      end
      i_fill_valid = 1'b1; i_data_from_mem = fill_data[w];
      mem[way][idx][w] = fill_data[w];
      if (w == 3) fd_q.push_back(cyc + 1);
      tick();
      i_fill_valid = 1'b0;
      if (w < 3) chk("busy_fill_word", 64'(o_busy), 64'd1);
    end
    chk("busy_after_fill", 64'(o_busy), 64'd0);
  endtask

  task automatic evict(input logic [0:0] way, input logic [2:0] idx, input int stall_word,
                       input int stall_n, input bit rnd);
    int acc; int stalls;
    i_evict_start = 1'b1; i_line_index = idx; i_line_way = way;
    for (int w = 0; w < 4; w++) ev_q.push_back('{mem[way][idx][w], (w == 3)});
    tick();
    i_evict_start = 1'b0;
    acc = 0; stalls = 0;
    for (int c = 0; c < 200 && acc < 4; c++) begin
      chk("busy_in_evict", 64'(o_busy), 64'd1);
      if (rnd) i_evict_ready = 1'($urandom);
      else if (o_evict_valid && acc == stall_word && stalls < stall_n) begin
        i_evict_ready = 1'b0; stalls++;
      end else i_evict_ready = 1'b1;
      @(negedge clk);
      if (o_evict_valid && i_evict_ready) acc++;
      tick();
    end
    i_evict_ready = 1'b0;
    chk("evict_word_count", 64'(acc), 64'd4);
    chk("busy_after_evict", 64'(o_busy), 64'd0);
    chk("evict_queue_drained", 64'(ev_q.size()), 64'd0);
    ev_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; i_core_req = 0; i_core_we = 0; i_index = 0; i_offset = 0; i_way = 0;
    i_dm_write = 0; i_data_from_core = 0; i_fill_start = 0; i_evict_start = 0;
    i_line_index = 0; i_line_way = 0; i_fill_valid = 0; i_data_from_mem = 0;
    i_evict_ready = 0;
    #1;
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_data_valid", 64'(o_data_valid), 64'd0);
    chk("reset_data", 64'(o_data), 64'd0);
    chk("reset_evict_valid", 64'(o_evict_valid), 64'd0);
    chk("reset_fill_done", 64'(o_fill_done), 64'd0);
    repeat (2) tick();
    nrst = 1'b1;
    tick();

    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++)
        for (int o = 0; o < 4; o++)
          core_op(1'b1, 1'(w), 3'(s), 2'(o), 4'hf, $urandom);

    // Full store then load.
    core_op(1'b1, 1'b1, 3'd5, 2'd2, 4'hf, 32'hDEADBEEF);
    core_op(1'b0, 1'b1, 3'd5, 2'd2, 4'h0, 32'h0);
    // Byte-lane merge; neighbours must be untouched.
    core_op(1'b1, 1'b0, 3'd6, 2'd1, 4'hf, 32'h11223344);
    core_op(1'b1, 1'b0, 3'd6, 2'd1, 4'b0001, 32'h000000AA);
    core_op(1'b0, 1'b0, 3'd6, 2'd1, 4'h0, 32'h0);
    core_op(1'b0, 1'b1, 3'd6, 2'd1, 4'h0, 32'h0);
    core_op(1'b0, 1'b0, 3'd6, 2'd0, 4'h0, 32'h0);
    core_op(1'b0, 1'b0, 3'd6, 2'd2, 4'h0, 32'h0);
    tick();
    chk("byte_merge_drained", 64'(ld_q.size()), 64'd0);

    // Refill set3/way0 with gaps and an ignored mid-burst store/load.
    for (int w = 0; w < 4; w++) fill_data[w] = 32'hA0 + 32'(w);
    fill_gap[0] = 0; fill_gap[1] = 2; fill_gap[2] = 1; fill_gap[3] = 0;
    fill(1'b0, 3'd3, 1'b0, 1'b1);
    tick();
    for (int o = 0; o < 4; o++) core_op(1'b0, 1'b0, 3'd3, 2'(o), 4'h0, 32'h0);
    core_op(1'b0, 1'b1, 3'd0, 2'd0, 4'h0, 32'h0);

    // Evict it with three cycles of back-pressure on word 1.
    evict(1'b0, 3'd3, 1, 3, 1'b0);

    // Reset mid-fill after two words.
    for (int w = 0; w < 4; w++) fill_data[w] = 32'hC0FFEE00 + 32'(w);
    i_fill_start = 1'b1; i_line_index = 3'd2; i_line_way = 1'b1;
    core_op(1'b0, 1'b1, 3'd5, 2'd2, 4'h0, 32'h0);
    i_fill_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      i_fill_valid = 1'b1; i_data_from_mem = fill_data[w];
      mem[1][2][w] = fill_data[w];
      tick();
    end
    i_fill_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_data", 64'(o_data), 64'd0);
    chk("rst_mid_data_valid", 64'(o_data_valid), 64'd0);
    chk("rst_mid_fill_done", 64'(o_fill_done), 64'd0);
    chk("rst_mid_evict_valid", 64'(o_evict_valid), 64'd0);
    chk("rst_mid_evict_last", 64'(o_evict_last), 64'd0);
    chk("rst_mid_evict_data", 64'(o_evict_data), 64'd0);
    tick(); tick();
    nrst = 1'b1;
    tick();
    for (int w = 0; w < 4; w++) begin fill_data[w] = 32'h5EED0000 + 32'(w); fill_gap[w] = 0; end
    fill(1'b1, 3'd2, 1'b0, 1'b0);
    for (int o = 0; o < 4; o++) core_op(1'b0, 1'b1, 3'd2, 2'(o), 4'h0, 32'h0);

    // Random mix of core traffic and bursts.
    for (int it = 0; it < 150; it++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 5) core_op(1'b0, 1'($urandom), 3'($urandom), 2'($urandom), 4'h0, 32'h0);
      else if (sel < 8)
        core_op(1'b1, 1'($urandom), 3'($urandom), 2'($urandom), 4'($urandom), $urandom);
      else if (sel == 8) begin
        for (int w = 0; w < 4; w++) begin
          fill_data[w] = $urandom; fill_gap[w] = int'($urandom_range(0, 2));
        end
        fill(1'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      end else evict(1'($urandom), 3'($urandom), 0, 0, 1'b1);
    end

    repeat (3) tick();
    chk("load_queue_drained", 64'(ld_q.size()), 64'd0);
    chk("fill_queue_drained", 64'(fd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
